// File: rtl/encrypt_iterative.sv
// -----------------------------------------------------------------------------
// encrypt_iterative
// Iterative AES encryption core (AES-128/192/256), one round per clock.
// The key schedule is supplied pre-expanded and must stay stable for the
// whole block; it is indexed directly by the round counter, not latched.
//
// Ports
//   clk     in   1     clock, rising edge
//   rst     in   1     synchronous active-high reset
//   start   in   1     request pulse, sampled only while busy=0
//   switch  in   2     key size: 00 -> 10 rounds, 01 -> 12, 1x -> 14
//   in      in   128   plaintext, in[127:120] = byte 0 (column-major)
//   key_e   in   1920  round key i at key_e[128*i +: 128]
//   out     out  128   ciphertext, held until the next block completes
//   busy    out  1     block in flight
//   done    out  1     one-cycle pulse when out is updated
// -----------------------------------------------------------------------------
module encrypt_iterative (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    switch,
  input  logic [127:0]  in,
  input  logic [1919:0] key_e,
  output logic [127:0]  out,
  output logic          busy,
  output logic          done
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Forward S-box, byte b lives at SBOX_TABLE[8*(255-b) +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  logic          fsm_reg;
  logic [3:0]    rnd_reg;
  logic [3:0]    nr_reg;
  logic [127:0]  state_reg;
  logic [127:0]  out_reg;
  logic          done_reg;

  logic [3:0]    nr_sel;
  logic [127:0]  rk_word;
  logic [127:0]  sr_word;
  logic [127:0]  mc_word;
  logic [127:0]  round_next;
  logic [127:0]  final_next;

  logic [7:0]    sb_b [16];
  logic [7:0]    sr_b [16];
  logic [7:0]    mc_b [16];

  assign nr_sel  = (switch == 2'b00) ? 4'd10 :
                   (switch == 2'b01) ? 4'd12 : 4'd14;

  // Round key for the round currently being computed.
  assign rk_word = key_e[{rnd_reg, 7'd0} +: 128];

  genvar gi;
  generate
    // SubBytes then ShiftRows: byte (row r, col c) takes byte (r, c+r mod 4).
    for (gi = 0; gi < 16; gi++) begin : g_byte
      assign sb_b[gi] = sbox(state_reg[127-8*gi -: 8]);
      assign sr_b[gi] = sb_b[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
      assign sr_word[127-8*gi -: 8] = sr_b[gi];
      assign mc_word[127-8*gi -: 8] = mc_b[gi];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_b[4*gi];
      assign a1 = sr_b[4*gi+1];
      assign a2 = sr_b[4*gi+2];
      assign a3 = sr_b[4*gi+3];
      // 3*x is written as xtime(x)^x.
      assign mc_b[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc_b[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc_b[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc_b[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  assign round_next = mc_word ^ rk_word;
  assign final_next = sr_word ^ rk_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg   <= ST_IDLE;
      rnd_reg   <= 4'd0;
      nr_reg    <= 4'd0;
      state_reg <= 128'h0;
      out_reg   <= 128'h0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        ST_IDLE: begin
          if (start) begin
            nr_reg    <= nr_sel;
            state_reg <= in ^ key_e[127:0];
            rnd_reg   <= 4'd1;
            fsm_reg   <= ST_RUN;
          end
        end
        default: begin
          if (rnd_reg == nr_reg) begin
            out_reg  <= final_next;
            done_reg <= 1'b1;
            fsm_reg  <= ST_IDLE;
          end else begin
            state_reg <= round_next;
            rnd_reg   <= rnd_reg + 4'd1;
          end
        end
      endcase
    end
  end

  assign out  = out_reg;
  assign busy = (fsm_reg == ST_RUN);
  assign done = done_reg;

endmodule

// File: doc/encrypt_iterative.md
# encrypt_iterative

Iterative AES encryption core, the forward-direction counterpart of the team's iterative decryptor. It takes one 128-bit plaintext block plus the full pre-expanded key schedule and applies one AES round per clock, supporting AES-128, AES-192 and AES-256. Its ciphertext output is bit-compatible with the decryptor's input, so the two blocks can be chained for loopback testing. It sits between the key-expansion logic and the decryptor or display path.

## Interface
- No parameters. Round count is selected at run time by `switch`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only while `busy`=0.
- `switch`  in  2  key size: 2'b00 → nr=10, 2'b01 → nr=12, 2'b10 or 2'b11 → nr=14.
- `in`  in  128  plaintext; `in[127:120]` is byte 0 (s0,0), column-major per FIPS-197.
- `key_e`  in  1920  expanded schedule; round key i = `key_e[128*i+127 : 128*i]`, for i=0..nr; unused upper bits are ignored.
- `out`  out  128  ciphertext, same byte order as `in`.
- `busy`  out  1  high while a block is in flight.
- `done`  out  1  one-cycle pulse when `out` is updated.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, round counter `rnd` counts 1..nr.
- IDLE → RUN when `start`=1. At that edge:
  - `nr` is latched from `switch`.
  - `state` is loaded with `in ^ rk0`.
  - `rnd` is set to 1.
- RUN, `rnd` < nr: each edge does `state ← MixColumns(ShiftRows(SubBytes(state))) ^ rk[rnd]`, then `rnd` increments.
- RUN, `rnd` == nr (final round):
  - `out ← ShiftRows(SubBytes(state)) ^ rk[nr]`; there is no MixColumns.
  - `done` is set to 1 for one cycle and the block returns to IDLE.
- `out` holds its value until the next final round or until reset.
- `in` is consumed only at the start edge.
- `key_e` must stay stable from the start edge through the final-round edge. It is not latched.
- The latched `nr` is immune to `switch` changes mid-block.
- `start` while `busy`=1 is ignored and not queued.
- The round datapath uses combinational `SubBytes`/`ShiftRows`/`MixColumns` functions. S-box lookups use a shared 256-entry combinational table.
- Arithmetic: `MixColumns` is over GF(2^8) with reduction polynomial 0x11B. `xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00)`. All XORs are 128-bit with no carries.

## Timing
- Reset values: `out`=128'h0, `busy`=0, `done`=0, state=IDLE, `rnd`=0, internal `state`=0.
- Latency: `start` sampled at edge T → `done`=1 and `out` valid in the cycle after edge T+nr. That is 10, 12 or 14 cycles for the three key sizes.
- `busy` is 1 from after edge T through the cycle after edge T+nr−1. `busy` is 0 in the `done` cycle.
- Back-to-back: `start` may be asserted in the `done` cycle. It is accepted at that edge, so throughput is one block per nr+1 cycles.
- Reset mid-operation aborts the block: no `done` pulse, `out` returns to 0, state returns to IDLE.
- `rst` and `start` on the same edge: `rst` wins.
- `done` never coincides with `busy`=1.

## Test plan
- AES-128, FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (expanded by the bench), `in`=00112233445566778899aabbccddeeff, `switch`=00.
  - Required: `done` 10 cycles after `start`, `out`=69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-192 and AES-256, same plaintext:
  - Keys 00..17 and 00..1f.
  - Required: `out`=dda97ca4864cdfe06eaf70a0ec0d7191 at latency 12, and 8ea2b7ca516745bfeafc49904b496089 at latency 14.
- FIPS-197 Appendix B, back-to-back:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, `in`=3243f6a8885a308d313198a2e0370734, with a second `start` asserted in the `done` cycle.
  - Required: both results equal 3925841d02dc09fbdc118597196a0b32, and the second `done` arrives 11 cycles after the first.
- `start` re-pulsed mid-block and `switch` toggled mid-block:
  - Required: ignored; latency and result are unchanged from the C.1 values.
- `rst` asserted at round 5 of an AES-128 block:
  - Required: `out`=0, `busy`=0, and no `done` pulse.
  - A following `start` then completes normally with the C.1 result.
- Loopback: C.1 ciphertext is fed into the decryptor with the same schedule.
  - Required: the decryptor returns 00112233445566778899aabbccddeeff.
